input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 135 +++++++++++++
 tb/tb_input_conditioner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Synchronizes, optionally debounces (macro INPUT_DEBOUNCE_EN), edge-detects and counts rises
// on N_CH asynchronous inputs, and produces an active-low CPU reset pulse after reset release.
module input_conditioner #(
  parameter int              N_CH          = 4,
  parameter int              SYNC_STAGES   = 2,
  parameter int              DB_TICKS      = 27000,
  parameter int              DB_CNT_W      = 16,
  parameter int              EVT_CNT_W     = 8,
  parameter logic [N_CH-1:0] RESET_LEVEL   = '0,
  parameter int              RST_PULSE_LEN = 8
) (
  input  logic                      clk27,
  input  logic                      reset,
  input  logic [N_CH-1:0]           din,
  input  logic [N_CH-1:0]           evt_clr,
  output logic [N_CH-1:0]           dout,
  output logic [N_CH-1:0]           rise,
  output logic [N_CH-1:0]           fall,
  output logic [N_CH*EVT_CNT_W-1:0] evt_cnt,
  output logic                      rst_out_n
);

  localparam logic [7:0] PULSE_LEN = 8'(RST_PULSE_LEN);

  // Out-of-range configurations elaborate this marker block; there is no other effect.
  if (N_CH < 1 || N_CH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_TICKS < 1 ||
      DB_CNT_W < 1 || EVT_CNT_W < 1 || RST_PULSE_LEN < 1 || RST_PULSE_LEN > 255) begin : g_bad_params
  end

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_r;
  logic [N_CH-1:0]                  s;
  logic [N_CH-1:0]                  dout_nxt;
  logic [N_CH-1:0]                  rise_r;
  logic [N_CH-1:0]                  fall_r;
  logic [N_CH-1:0][EVT_CNT_W-1:0]   evt_r;
  logic [7:0]                       pulse_cnt_r;
  logic                             rst_out_n_r;

  // Synchronizer chain; stage 0 samples din, the last stage is the sync value.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_r[SYNC_STAGES-1];

`ifdef INPUT_DEBOUNCE_EN
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_TICKS - 1);

  logic [N_CH-1:0][DB_CNT_W-1:0] db_cnt_r;
  logic [N_CH-1:0][DB_CNT_W-1:0] db_cnt_nxt;
  logic [N_CH-1:0]               dout_r;

  // A new level must differ from dout for DB_TICKS consecutive cycles; any return restarts.
  always_comb begin
    dout_nxt   = dout_r;
    db_cnt_nxt = db_cnt_r;
    for (int k = 0; k < N_CH; k++) begin
      if (s[k] == dout_r[k]) begin
        db_cnt_nxt[k] = '0;
      end else if (db_cnt_r[k] == DB_LAST) begin
        dout_nxt[k]   = s[k];
        db_cnt_nxt[k] = '0;
      end else begin
        db_cnt_nxt[k] = db_cnt_r[k] + DB_CNT_W'(1);
      end
    end
  end

  // Debounced level and counters.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      dout_r   <= RESET_LEVEL;
      db_cnt_r <= '0;
    end else begin
      dout_r   <= dout_nxt;
      db_cnt_r <= db_cnt_nxt;
    end
  end

  assign dout = dout_r;
`else
  // Without debounce the last sync stage is the output; its next value is the stage before.
  assign dout_nxt = sync_r[SYNC_STAGES-2];
  assign dout     = s;
`endif

  // Edge pulses are registered together with the level change so they align with dout.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      rise_r <= dout_nxt & ~dout;
      fall_r <= ~dout_nxt & dout;
    end
  end

  // Rise counters wrap freely; a clear coincident with a rise leaves the count at one.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      evt_r <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (evt_clr[k]) begin
          evt_r[k] <= EVT_CNT_W'(rise_r[k]);
        end else begin
          evt_r[k] <= evt_r[k] + EVT_CNT_W'(rise_r[k]);
        end
      end
    end
  end

  // CPU reset pulse: counts up once after release and parks at the terminal value.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      pulse_cnt_r <= 8'd0;
      rst_out_n_r <= 1'b0;
    end else begin
      if (pulse_cnt_r != PULSE_LEN) begin
        pulse_cnt_r <= pulse_cnt_r + 8'd1;
      end
      rst_out_n_r <= (pulse_cnt_r == PULSE_LEN);
    end
  end

  assign rise      = rise_r;
  assign fall      = fall_r;
  assign evt_cnt   = evt_r;
  assign rst_out_n = rst_out_n_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected dout/rise/fall events are queued when din is
// driven and compared each cycle; evt_cnt and rst_out_n are tracked by a small reference model.
module tb_input_conditioner;

  localparam int NCH = 2;
  localparam int SS  = 2;
  localparam int DBT = 4;
  localparam int EW  = 3;
  localparam int RPL = 8;
`ifdef INPUT_DEBOUNCE_EN
  localparam int LAT  = SS + DBT;
  localparam int MINW = DBT;
`else
  localparam int LAT  = SS;
  localparam int MINW = 1;
`endif

  logic              clk27 = 1'b0;
  logic              reset = 1'b0;
  logic [NCH-1:0]    din = 2'b10;
  logic [NCH-1:0]    evt_clr = 2'b00;
  logic [NCH-1:0]    dout, rise, fall;
  logic [NCH*EW-1:0] evt_cnt;
  logic              rst_out_n;

  typedef struct {
    int   ecyc;
    int   ch;
    logic lvl;
  } exp_evt_t;

  exp_evt_t   sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         rel_cyc = 0;
  bit         mon_en  = 1'b0;
  logic [1:0] exp_dout = 2'b10;
  logic [EW-1:0] exp_evt[NCH];

  input_conditioner #(
    .N_CH(NCH), .SYNC_STAGES(SS), .DB_TICKS(DBT), .DB_CNT_W(16), .EVT_CNT_W(EW),
    .RESET_LEVEL(2'b10), .RST_PULSE_LEN(RPL)
  ) dut (
    .clk27(clk27), .reset(reset), .din(din), .evt_clr(evt_clr), .dout(dout),
    .rise(rise), .fall(fall), .evt_cnt(evt_cnt), .rst_out_n(rst_out_n)
  );

  initial forever #5 clk27 = ~clk27;

  always @(posedge clk27) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle scoreboard: events due this cycle set the expected pulses and level.
  always @(negedge clk27) begin
    logic [1:0] er, ef;
    if (mon_en) begin
      er = 2'b00;
      ef = 2'b00;
      for (int k = 0; k < NCH; k++) check_eq("evt_cnt", evt_cnt[k*EW +: EW], exp_evt[k]);
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].ecyc == cyc) begin
          if (sb_q[i].lvl) er[sb_q[i].ch] = 1'b1;
          else             ef[sb_q[i].ch] = 1'b1;
          sb_q.delete(i);
        end else if (sb_q[i].ecyc < cyc) begin
          check_eq("missed_event", cyc, sb_q[i].ecyc);
          sb_q.delete(i);
        end
      end
      exp_dout = (exp_dout | er) & ~ef;
      check_eq("rise", rise, er);
      check_eq("fall", fall, ef);
      check_eq("dout", dout, exp_dout);
      check_eq("rst_out_n", rst_out_n, (cyc - rel_cyc) > RPL);
      for (int k = 0; k < NCH; k++)
        exp_evt[k] = evt_clr[k] ? EW'(er[k]) : exp_evt[k] + EW'(er[k]);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk27);
    #2;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_eq("rst_dout", dout, 2'b10);
    check_eq("rst_rise", rise, 2'b00);
    check_eq("rst_fall", fall, 2'b00);
    check_eq("rst_evt", evt_cnt, 6'd0);
    check_eq("rst_out_n_low", rst_out_n, 1'b0);
    wait_cyc(3);
    check_eq("rst_hold_dout", dout, 2'b10);
    check_eq("rst_hold_out_n", rst_out_n, 1'b0);
    sb_q.delete();
    exp_dout   = 2'b10;
    exp_evt[0] = '0;
    exp_evt[1] = '0;
    reset   = 1'b0;
    rel_cyc = cyc;
    mon_en  = 1'b1;
  endtask

  // Toggle the masked channels for w cycles; pulses shorter than MINW must be discarded.
  task automatic press(input logic [1:0] mask, input int w, input int gap);
    int c;
    c   = cyc;
    din = din ^ mask;
    for (int k = 0; k < NCH; k++) begin
      if (mask[k] && w >= MINW) begin
        sb_q.push_back('{c + LAT, k, din[k]});
        sb_q.push_back('{c + w + LAT, k, ~din[k]});
      end
    end
    wait_cyc(w);
    din = din ^ mask;
    wait_cyc(gap);
  endtask

  initial begin
    int c;
    exp_evt[0] = '0;
    exp_evt[1] = '0;
    wait_cyc(2);
    do_reset();
    wait_cyc(12);
    check_eq("release_out_n", rst_out_n, 1'b1);
    check_eq("release_dout", dout, 2'b10);

    press(2'b01, 8, 10);
    check_eq("single_press_evt", evt_cnt[EW-1:0], 3'd1);

    press(2'b01, 3, 10);
    check_eq("glitch3_evt", evt_cnt[EW-1:0], (MINW <= 3) ? 3'd2 : 3'd1);

    press(2'b10, 1, 10);
    check_eq("glitch1_ch1_dout", dout[1], 1'b1);

    press(2'b11, 6, 12);

    evt_clr = 2'b01;
    wait_cyc(1);
    evt_clr = 2'b00;
    wait_cyc(1);
    check_eq("clear_evt", evt_cnt[EW-1:0], 3'd0);

    repeat (9) press(2'b01, 5, 10);
    check_eq("wrap9_evt", evt_cnt[EW-1:0], 3'd1);

    c      = cyc;
    din[0] = 1'b1;
    sb_q.push_back('{c + LAT, 0, 1'b1});
    sb_q.push_back('{c + 8 + LAT, 0, 1'b0});
    wait_cyc(LAT);
    evt_clr = 2'b01;
    wait_cyc(1);
    evt_clr = 2'b00;
    wait_cyc(8 - LAT - 1);
    din[0] = 1'b0;
    wait_cyc(12);
    check_eq("clear_with_rise", evt_cnt[EW-1:0], 3'd1);

    c      = cyc;
    din[1] = 1'b0;
    sb_q.push_back('{c + LAT, 1, 1'b0});
    wait_cyc(3);
    do_reset();
    sb_q.push_back('{rel_cyc + LAT, 1, 1'b0});
    wait_cyc(14);
    check_eq("post_reset_dout1", dout[1], 1'b0);
    check_eq("post_reset_out_n", rst_out_n, 1'b1);

    c      = cyc;
    din[1] = 1'b1;
    sb_q.push_back('{c + LAT, 1, 1'b1});
    wait_cyc(12);
    check_eq("final_queue_empty", sb_q.size(), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
